// File: rtl/alu_muldiv_if.sv
// Request/response bus of the execute-stage ALU: request side carries the
// operands and op select, response side carries the registered result.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [2:0]      func;
  logic            control;
  logic            m_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (
    output in_valid, in_a, in_b, func, control, m_sel, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, func, control, m_sel, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// RV32 execute-stage ALU: single-cycle base ops plus RV32M multiply/divide on
// a shared iterative radix-2 datapath (shift-add / restoring shift-subtract).
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_muldiv_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_r;
  logic [XLEN-1:0] acc_r, lo_r, opd_r, result_r;
  logic [SHW-1:0]  cnt_r;
  logic [2:0]      func_r;
  logic            neg_r, in_ready_r, out_valid_r, busy_r;

  logic [XLEN-1:0]   base_s, spec_res_s, a_mag_s, b_mag_s, acc_nx_s, lo_nx_s, fin_s;
  logic [SHW-1:0]    shamt_s;
  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s;
  logic              div_zero_s, ovf_s, special_s;
  logic [XLEN:0]     mul_sum_s, rem_sh_s, diff_s;
  logic [2*XLEN-1:0] prod_s;

  assign shamt_s = bus.in_b[SHW-1:0];

  // Base integer operations, funct3 encoded
  always_comb begin
    base_s = ZERO;
    case (bus.func)
      3'b000:  base_s = bus.control ? (bus.in_a - bus.in_b) : (bus.in_a + bus.in_b);
      3'b001:  base_s = bus.in_a << shamt_s;
      3'b010:  base_s = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      3'b011:  base_s = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
      3'b100:  base_s = bus.in_a ^ bus.in_b;
      3'b101: begin
        if (bus.control) base_s = $signed(bus.in_a) >>> shamt_s;
        else             base_s = bus.in_a >> shamt_s;
      end
      3'b110:  base_s = bus.in_a | bus.in_b;
      3'b111:  base_s = bus.in_a & bus.in_b;
      default: base_s = ZERO;
    endcase
  end

  // Operand signedness per M-op; the iterative core works on magnitudes only
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (bus.func)
      3'b001, 3'b100, 3'b110: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      3'b010:                 begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
      default:                begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
    endcase
  end

  assign a_neg_s = a_sgn_s & bus.in_a[XLEN-1];
  assign b_neg_s = b_sgn_s & bus.in_b[XLEN-1];
  assign a_mag_s = a_neg_s ? (ZERO - bus.in_a) : bus.in_a;
  assign b_mag_s = b_neg_s ? (ZERO - bus.in_b) : bus.in_b;
  // Remainder sign follows the dividend; everything else is the XOR of signs
  assign neg_s   = (bus.func == 3'b110) ? a_neg_s : (a_neg_s ^ b_neg_s);

  assign div_zero_s = (bus.in_b == ZERO);
  assign ovf_s      = ~bus.func[0] & (bus.in_a == MIN) & (bus.in_b == ONES);
  assign special_s  = bus.m_sel & bus.func[2] & (div_zero_s | ovf_s);

  always_comb begin
    if (div_zero_s)  spec_res_s = bus.func[1] ? bus.in_a : ONES;
    else if (ovf_s)  spec_res_s = bus.func[1] ? ZERO : bus.in_a;
    else             spec_res_s = ZERO;
  end

  assign mul_sum_s = {1'b0, acc_r} + {1'b0, (lo_r[0] ? opd_r : ZERO)};
  assign rem_sh_s  = {acc_r, lo_r[XLEN-1]};
  assign diff_s    = rem_sh_s - {1'b0, opd_r};

  // One radix-2 step: {acc,lo} is product / {remainder,quotient}
  always_comb begin
    if (!func_r[2]) begin
      acc_nx_s = mul_sum_s[XLEN:1];
      lo_nx_s  = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end else if (!diff_s[XLEN]) begin
      acc_nx_s = diff_s[XLEN-1:0];
      lo_nx_s  = {lo_r[XLEN-2:0], 1'b1};
    end else begin
      acc_nx_s = rem_sh_s[XLEN-1:0];
      lo_nx_s  = {lo_r[XLEN-2:0], 1'b0};
    end
  end

  assign prod_s = neg_r ? ({(2*XLEN){1'b0}} - {acc_nx_s, lo_nx_s}) : {acc_nx_s, lo_nx_s};

  always_comb begin
    case (func_r)
      3'b000:                 fin_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_s = neg_r ? (ZERO - lo_nx_s) : lo_nx_s;
      3'b110, 3'b111:         fin_s = neg_r ? (ZERO - acc_nx_s) : acc_nx_s;
      default:                fin_s = ZERO;
    endcase
  end

  // Control FSM with registered handshake outputs; flush beats every handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= ZERO;
      lo_r        <= ZERO;
      opd_r       <= ZERO;
      result_r    <= ZERO;
      cnt_r       <= {SHW{1'b0}};
      func_r      <= 3'b000;
      neg_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (flush) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            func_r     <= bus.func;
            in_ready_r <= 1'b0;
            if (!bus.m_sel || special_s) begin
              result_r    <= bus.m_sel ? spec_res_s : base_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              acc_r   <= ZERO;
              lo_r    <= bus.func[2] ? a_mag_s : b_mag_s;
              opd_r   <= bus.func[2] ? b_mag_s : a_mag_s;
              neg_r   <= neg_s;
              cnt_r   <= {SHW{1'b1}};
              busy_r  <= 1'b1;
              state_r <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_r <= acc_nx_s;
          lo_r  <= lo_nx_s;
          if (cnt_r == {SHW{1'b0}}) begin
            result_r    <= fin_s;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = result_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected results come from a behavioural
// model using native SV arithmetic and are queued at issue, popped at output.
module tb_alu_muldiv;
  logic clk;
  logic rst_n;
  logic flush;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] scb[$];

  alu_muldiv_if #(.XLEN(32)) bus ();

  alu_muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f, input logic c, input logic m);
    logic [63:0]        ea, eb, p;
    logic signed [31:0] sa, sbv;
    logic [31:0]        r;
    sa  = a;
    sbv = b;
    r   = 32'h0;
    if (!m) begin
      case (f)
        3'd0: r = c ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sbv) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          if (c) r = sa >>> b[4:0];
          else   r = a >> b[4:0];
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else begin
      ea = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      case (f)
        3'd0: r = p[31:0];
        3'd1, 3'd2, 3'd3: r = p[63:32];
        3'd4: r = (b == 32'h0) ? 32'hFFFF_FFFF :
                  ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sbv));
        3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
        3'd6: r = (b == 32'h0) ? a :
                  ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sbv));
        default: r = (b == 32'h0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  // Drives one request (starting at a negedge), pushes its expectation, waits for out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic c, input logic m,
                       output logic [31:0] got, output int lat, output int bcnt);
    int w;
    bus.in_a = a; bus.in_b = b; bus.func = f; bus.control = c; bus.m_sel = m;
    bus.in_valid = 1'b1;
    scb.push_back(model(a, b, f, c, m));
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; bcnt = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    got = bus.out_result;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_a = 32'h0; bus.in_b = 32'h0; bus.func = 3'd0;
    bus.control = 1'b0; bus.m_sel = 1'b0; bus.out_ready = 1'b0;
    flush = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_result !== 32'h0) $display("FAIL reset out_result got=%h exp=0", bus.out_result); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset busy got=%b exp=0", bus.busy); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_base();
    logic [31:0] ta [10] = '{32'd5, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_F0F0,
                             32'h8000_0000, 32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0};
    logic [31:0] tb [10] = '{32'd7, 32'd7, 32'd33, 32'd1, 32'd1, 32'h0000_0FF0,
                             32'd36, 32'd36, 32'h0000_0FF0, 32'h0000_0FF0};
    logic [2:0]  tf [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic        tc [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] got, exp;
    int lat, bcnt;
    for (int i = 0; i < 10; i++) begin
      issue(ta[i], tb[i], tf[i], tc[i], 1'b0, got, lat, bcnt);
      exp = scb.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL base[%0d] result got=%h exp=%h", i, got, exp); else pass_cnt++;
      total_cnt++; if (lat != 1) $display("FAIL base[%0d] latency got=%0d exp=1", i, lat); else pass_cnt++;
      take();
    end
  endtask

  task automatic test_mul();
    logic [31:0] ta [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0123_4567};
    logic [31:0] tb [5] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h89AB_CDEF};
    logic [2:0]  tf [5] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd1};
    logic [31:0] got, exp;
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], tf[i], 1'b0, 1'b1, got, lat, bcnt);
      exp = scb.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL mul[%0d] result got=%h exp=%h", i, got, exp); else pass_cnt++;
      total_cnt++; if (lat != 33) $display("FAIL mul[%0d] latency got=%0d exp=33", i, lat); else pass_cnt++;
      total_cnt++; if (bcnt != 32) $display("FAIL mul[%0d] busy_cycles got=%0d exp=32", i, bcnt); else pass_cnt++;
      take();
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] tb [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [2:0]  tf [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] got, exp;
    int lat, bcnt;
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], tf[i], 1'b0, 1'b1, got, lat, bcnt);
      exp = scb.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL div[%0d] result got=%h exp=%h", i, got, exp); else pass_cnt++;
      total_cnt++; if (lat != 33) $display("FAIL div[%0d] latency got=%0d exp=33", i, lat); else pass_cnt++;
      take();
    end
  endtask

  task automatic test_special();
    logic [31:0] ta [6] = '{32'd9, 32'd9, 32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [2:0]  tf [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] got, exp;
    int lat, bcnt;
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], tf[i], 1'b0, 1'b1, got, lat, bcnt);
      exp = scb.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL special[%0d] result got=%h exp=%h", i, got, exp); else pass_cnt++;
      total_cnt++; if (lat != 1) $display("FAIL special[%0d] latency got=%0d exp=1", i, lat); else pass_cnt++;
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, exp;
    int lat, bcnt;
    issue(32'd100, 32'd7, 3'd5, 1'b0, 1'b1, got, lat, bcnt);
    exp = scb.pop_front();
    total_cnt++; if (got !== exp) $display("FAIL bp result got=%h exp=%h", got, exp); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.out_result !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] result=%h valid=%b ready=%b exp=%h/1/0",
                 i, bus.out_result, bus.out_valid, bus.in_ready, exp);
      else pass_cnt++;
    end
    // New request presented during the output handshake must wait one cycle
    bus.in_a = 32'd1; bus.in_b = 32'd1; bus.func = 3'd0; bus.control = 1'b0; bus.m_sel = 1'b0;
    bus.in_valid = 1'b1;
    scb.push_back(model(32'd1, 32'd1, 3'd0, 1'b0, 1'b0));
    take();
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL bp_release ready=%b valid=%b exp=1/0", bus.in_ready, bus.out_valid);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = scb.pop_front();
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== exp)
      $display("FAIL bp_next valid=%b result=%h exp=1/%h", bus.out_valid, bus.out_result, exp);
    else pass_cnt++;
    take();
  endtask

  task automatic test_flush();
    logic [31:0] got, exp;
    int lat, bcnt, seen;
    bus.in_a = 32'd1000; bus.in_b = 32'd3; bus.func = 3'd4; bus.control = 1'b0; bus.m_sel = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL flush_pre busy got=%b exp=1", bus.busy); else pass_cnt++;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL flush_idle busy=%b ready=%b valid=%b exp=0/1/0", bus.busy, bus.in_ready, bus.out_valid);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    total_cnt++; if (seen != 0) $display("FAIL flush_no_valid got=%0d exp=0", seen); else pass_cnt++;
    issue(32'd1, 32'd1, 3'd0, 1'b0, 1'b0, got, lat, bcnt);
    exp = scb.pop_front();
    total_cnt++; if (got !== exp) $display("FAIL flush_add result got=%h exp=%h", got, exp); else pass_cnt++;
    total_cnt++; if (lat != 1) $display("FAIL flush_add latency got=%0d exp=1", lat); else pass_cnt++;
    take();
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    int lat, bcnt;
    bus.in_a = 32'h1234_5678; bus.in_b = 32'h9ABC_DEF0; bus.func = 3'd0; bus.control = 1'b0; bus.m_sel = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_result !== 32'h0)
      $display("FAIL reset_mid ready=%b valid=%b busy=%b result=%h exp=1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_result);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1, got, lat, bcnt);
    exp = scb.pop_front();
    total_cnt++; if (got !== exp) $display("FAIL reset_mul result got=%h exp=%h", got, exp); else pass_cnt++;
    total_cnt++; if (lat != 33) $display("FAIL reset_mul latency got=%0d exp=33", lat); else pass_cnt++;
    take();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, got, exp;
    logic [2:0]  f;
    logic        c, m, spec;
    int lat, bcnt, exp_lat;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom;
      f = 3'($urandom_range(0, 7));
      c = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) b = 32'h0;
      if (i == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f = 3'd6; m = 1'b1; end
      spec = m && f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_lat = (m && !spec) ? 33 : 1;
      issue(a, b, f, c, m, got, lat, bcnt);
      exp = scb.pop_front();
      total_cnt++;
      if (got !== exp)
        $display("FAIL b2b[%0d] m=%b f=%0d c=%b a=%h b=%h got=%h exp=%h", i, m, f, c, a, b, got, exp);
      else pass_cnt++;
      total_cnt++; if (lat != exp_lat) $display("FAIL b2b[%0d] latency got=%0d exp=%0d", i, lat, exp_lat); else pass_cnt++;
      take();
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_base();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    total_cnt++;
    if (scb.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0", scb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
